// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide sequencer that owns the HI/LO registers.
//
// It handles MULT, MULTU, DIV and DIVU. The multiplier is a radix-2 shift-add
// unit and the divider is a restoring divider. Both work on operand magnitudes
// and produce one bit per cycle. A final FIX cycle applies the sign correction
// and writes HI/LO. The block also services MTHI/MTLO writes while idle.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   issue request, sampled only in IDLE
//   op        in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa/opb   in   rs / rt operand values
//   flush     in   abort the in-flight op; in IDLE it drops a same-cycle start
//   mthi/mtlo in   write HI/LO from wdata (IDLE only)
//   wdata     in   MTHI/MTLO data
//   busy      out  op in flight (state != IDLE)
//   done      out  one-cycle pulse, HI/LO just received a result
//   div_zero  out  valid with done: last divide had a zero divisor
//   hi/lo     out  HI/LO registers
//
// state | meaning
// IDLE  | waiting for start; accepts mthi/mtlo
// CALC  | one multiply/divide iteration per cycle, XLEN cycles
// FIX   | sign fixup, HI/LO write, done pulse
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            flush,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]      state_q,    state_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic            is_div_q,   is_div_d;
    logic            neg_q,      neg_d;       // negate product / quotient
    logic            neg_rem_q,  neg_rem_d;   // remainder takes sign of dividend
    logic            dz_q,       dz_d;        // current op is a divide by zero
    logic [XLEN-1:0] acc_q,      acc_d;       // product high half / partial remainder
    logic [XLEN-1:0] qr_q,       qr_d;        // multiplier -> product low / dividend -> quotient
    logic [XLEN-1:0] dvs_q,      dvs_d;       // multiplicand / divisor magnitude
    logic [XLEN-1:0] hi_q,       hi_d;
    logic [XLEN-1:0] lo_q,       lo_d;
    logic            done_q,     done_d;
    logic            div_zero_q, div_zero_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // op[0] set means unsigned, so only signed ops take magnitudes
    assign a_neg = !op[0] && opa[XLEN-1];
    assign b_neg = !op[0] && opb[XLEN-1];
    assign a_mag = a_neg ? -opa : opa;
    assign b_mag = b_neg ? -opb : opb;

    // Shift-add: add multiplicand when the current multiplier bit is set, then
    // shift the whole {carry, acc, qr} right by one. Product bits enter qr from the top.
    assign mul_sum = {1'b0, acc_q} + (qr_q[0] ? {1'b0, dvs_q} : '0);

    // Restoring divide: bring the next dividend bit into the remainder and try
    // to subtract. The remainder is always below the divisor, so XLEN+1 bits
    // are enough to hold the shifted value.
    assign div_shift = {acc_q, qr_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};

    assign prod     = {acc_q, qr_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -qr_q : qr_q;
    assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        acc_d      = acc_q;
        qr_d       = qr_q;
        dvs_d      = dvs_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start && !flush) begin
                    div_zero_d = 1'b0;
                    cnt_d      = '0;
                    is_div_d   = op[1];
                    neg_d      = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    dz_d       = 1'b0;
                    if (op[1] && (opb == '0)) begin
                        // Zero divisor skips iteration: HI gets the raw dividend,
                        // LO all ones, and no sign correction is applied.
                        dz_d      = 1'b1;
                        neg_d     = 1'b0;
                        neg_rem_d = 1'b0;
                        acc_d     = opa;
                        qr_d      = '1;
                        dvs_d     = '0;
                        state_d   = S_FIX;
                    end else if (op[1]) begin
                        acc_d   = '0;
                        qr_d    = a_mag;
                        dvs_d   = b_mag;
                        state_d = S_CALC;
                    end else begin
                        acc_d   = '0;
                        qr_d    = b_mag;
                        dvs_d   = a_mag;
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[XLEN]) begin
                            acc_d = div_diff[XLEN-1:0];
                            qr_d  = {qr_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = div_shift[XLEN-1:0];
                            qr_d  = {qr_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        qr_d  = {mul_sum[0], qr_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d     = 1'b1;
                    div_zero_d = dz_q;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            acc_q      <= '0;
            qr_q       <= '0;
            dvs_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            acc_q      <= acc_d;
            qr_q       <= qr_d;
            dvs_q      <= dvs_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Testbench for mdu_seq: directed vector table, hand-written corner-case
// sequences, and randomized ops checked against an arithmetic reference model.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst, start, flush, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] opa, opb, wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    mdu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, truncating division.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            2'b01: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF; z = 1'b1;
                end else if (o == 2'b10) begin
                    sp = sa / sb; l = sp[31:0];
                    sp = sa % sb; h = sp[31:0];
                end else begin
                    up = ua / ub; l = up[31:0];
                    up = ua % ub; h = up[31:0];
                end
            end
        endcase
    endfunction

    // Bounded wait for done; lat = edges after the start edge.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rz,
                          output int lat, output int bcnt);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        rh = hi; rl = lo; rz = div_zero;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gh, gl, eh, el, prev_hi, prev_lo;
        logic        gz, ez;
        int          lat, bcnt, ndone;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0};
        vecs[5]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{2'b00, 32'd0,         32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'd1,          32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{2'b10, 32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'b01, 32'd12345,     32'd678,        32'd0,         32'd8369910,   1'b0};
        vecs[11] = '{2'b11, 32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF, 1'b1};

        rst = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; opa = '0; opb = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz",   div_zero, 0);
        check("rst_hi",   hi, 0);
        check("rst_lo",   lo, 0);
        rst = 1'b0;

        // Directed table; consecutive ops also exercise start in the done cycle.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, gh, gl, gz, lat, bcnt);
            check($sformatf("v%0d_hi", i),   gh, vecs[i].hi);
            check($sformatf("v%0d_lo", i),   gl, vecs[i].lo);
            check($sformatf("v%0d_dz", i),   gz, vecs[i].dz);
            check($sformatf("v%0d_lat", i),  lat,  vecs[i].dz ? 1 : 33);
            check($sformatf("v%0d_busy", i), bcnt, vecs[i].dz ? 1 : 33);
        end

        // div_zero clears on the next start; done is a single-cycle pulse.
        @(negedge clk);
        op = 2'b11; opa = 32'd100; opb = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("dz_clear", div_zero, 0);
        wait_done(lat, bcnt);
        check("dz_next_lo", lo, 14);
        @(posedge clk); #1;
        check("done_pulse", done, 0);

        // Flush ten cycles into a MULT with preloaded HI/LO.
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_hi", hi, 32'h1234);
        check("mt_lo", lo, 32'h1234);
        @(negedge clk);
        op = 2'b00; opa = 32'hFFFF_FFFD; opb = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("flush_nodone", ndone, 0);
        check("flush_hi", hi, 32'h1234);
        check("flush_lo", lo, 32'h1234);

        // Second start and mthi while busy are ignored.
        @(negedge clk);
        op = 2'b11; opa = 32'd100; opb = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        op = 2'b01; opa = 32'd3; opb = 32'd3; start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("busy_mthi_ign", hi, 32'h1234);
        lat = 4;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_lat", lat, 33);
        check("busy_lo", lo, 14);
        check("busy_hi", hi, 2);
        @(posedge clk); #1;
        check("busy_noqueue", busy, 0);

        // mthi with start in the same IDLE cycle: write lands, op accepted, result overwrites.
        @(negedge clk);
        op = 2'b11; opa = 32'd100; opb = 32'd7; start = 1'b1; mthi = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("same_mthi_hi", hi, 32'hABCD);
        check("same_busy", busy, 1);
        wait_done(lat, bcnt);
        check("same_hi", hi, 2);
        check("same_lo", lo, 14);

        // flush in IDLE drops start, mtlo still writes.
        @(negedge clk);
        op = 2'b00; opa = 32'd9; opb = 32'd9; start = 1'b1; flush = 1'b1; mtlo = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; mtlo = 1'b0;
        check("idle_flush_busy", busy, 0);
        check("idle_flush_lo", lo, 32'h55);
        @(posedge clk); #1;
        check("idle_flush_done", done, 0);

        // flush during the FIX cycle discards the result.
        prev_hi = hi; prev_lo = lo;
        @(negedge clk);
        op = 2'b11; opa = 32'd7; opb = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fix_flush_done", done, 0);
        check("fix_flush_busy", busy, 0);
        check("fix_flush_hi", hi, prev_hi);
        check("fix_flush_lo", lo, prev_lo);

        // Asynchronous reset five cycles into a DIV.
        @(negedge clk);
        op = 2'b10; opa = 32'hFFFF_FFF9; opb = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dz",   div_zero, 0);
        check("arst_hi",   hi, 0);
        check("arst_lo",   lo, 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          mode;
            ro   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 9) ra = 32'h8000_0000;
            case (mode)
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 9);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, eh, el, ez);
            run_op(ro, ra, rb, gh, gl, gz, lat, bcnt);
            check($sformatf("r%0d_hi", i),  gh, eh);
            check($sformatf("r%0d_lo", i),  gl, el);
            check($sformatf("r%0d_dz", i),  gz, ez);
            check($sformatf("r%0d_lat", i), lat, ez ? 1 : 33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
